// File: rtl/fc_mac_accum_param_2_pkg.sv
// Shared definitions for the FC multiply-accumulate stage.
//   - default layer geometry (input/output neuron counts, lane count, width)
//   - controller state encoding
//   - counter width helper that never yields a zero-width vector
package fc_mac_accum_param_2_pkg;

  localparam int INNEURON_DEF   = 64;
  localparam int OUTNEURON_DEF  = 10;
  localparam int PO_DEF         = 2;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output-neuron lane: dual signed multiply-add into an accumulator,
// plus the scale / optional ReLU / saturate path that forms the lane result.
//   clk, reset          : clock, asynchronous active-high reset
//   en                  : beat accepted this cycle
//   last                : accepted beat is the final one of the group
//   neuron_a/b          : input neurons for this beat
//   weight_a/b          : this lane's weights for this beat
//   result              : saturated result of (acc + this beat) >>> FRAC_BITS,
//                         valid to sample on the last beat of a group
module fc_mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int FRAC_BITS  = 6,
  parameter int RELU       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         last,
  input  logic signed [DATA_WIDTH-1:0] neuron_a,
  input  logic signed [DATA_WIDTH-1:0] neuron_b,
  input  logic signed [DATA_WIDTH-1:0] weight_a,
  input  logic signed [DATA_WIDTH-1:0] weight_b,
  output logic        [DATA_WIDTH-1:0] result
);

  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]        prod_a;
  logic signed [PW-1:0]        prod_b;
  logic signed [ACC_WIDTH-1:0] ext_a;
  logic signed [ACC_WIDTH-1:0] ext_b;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] clipped;

  assign prod_a  = neuron_a * weight_a;
  assign prod_b  = neuron_b * weight_b;
  assign ext_a   = {{(ACC_WIDTH-PW){prod_a[PW-1]}}, prod_a};
  assign ext_b   = {{(ACC_WIDTH-PW){prod_b[PW-1]}}, prod_b};
  assign sum     = acc + ext_a + ext_b;
  assign shifted = sum >>> FRAC_BITS;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    clipped = shifted;
    if ((RELU != 0) && (shifted < 0)) clipped = '0;
    result = clipped[DATA_WIDTH-1:0];
    if (clipped > SAT_MAX) result = SAT_MAX[DATA_WIDTH-1:0];
    if (clipped < SAT_MIN) result = SAT_MIN[DATA_WIDTH-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   acc <= '0;
    else if (en) acc <= last ? '0 : sum;
  end

endmodule

// File: rtl/fc_mac_accum_param_2.sv
// FC layer multiply-accumulate stage fed by the weight address generator and
// the dual-port weight ROM. Two weight words and two input neurons arrive per
// beat; PO lanes accumulate INNEURON inputs and emit one scaled, saturated
// group per output-neuron block.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : begin one layer pass (honoured only when idle)
//   in_valid/in_ready : beat handshake; in_ready also enables the generator
//   weight_a/b   : ROM words, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   neuron_a/b   : input neurons paired with weight_a/b
//   out_valid/out_ready : result group handshake
//   out_data     : result group, same lane layout as the weights
//   out_group    : index of the group in out_data
//   done         : one-cycle pulse after the last group is accepted
module fc_mac_accum_param_2
  import fc_mac_accum_param_2_pkg::*;
#(
  parameter int INNEURON   = INNEURON_DEF,
  parameter int OUTNEURON  = OUTNEURON_DEF,
  parameter int PO         = PO_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = 24,
  parameter int FRAC_BITS  = 6,
  parameter int RELU       = 0,
  localparam int GROUPS_L  = OUTNEURON / PO,
  localparam int GROUP_W   = cnt_width(GROUPS_L)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PO*DATA_WIDTH-1:0] weight_a,
  input  logic [PO*DATA_WIDTH-1:0] weight_b,
  input  logic [DATA_WIDTH-1:0]    neuron_a,
  input  logic [DATA_WIDTH-1:0]    neuron_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PO*DATA_WIDTH-1:0] out_data,
  output logic [GROUP_W-1:0]       out_group,
  output logic                     done
);

  localparam int BEATS_PER_GROUP = INNEURON / 2;
  localparam int GROUPS          = GROUPS_L;
  localparam int BEAT_W          = cnt_width(BEATS_PER_GROUP);

  state_t                   state;
  state_t                   state_next;
  logic [BEAT_W-1:0]        beat_cnt;
  logic [GROUP_W-1:0]       group_cnt;
  logic [PO*DATA_WIDTH-1:0] lane_results;
  logic                     accept;
  logic                     last_beat;
  logic                     last_group;
  logic                     drain_ack;

  assign in_ready   = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_cnt == BEAT_W'(BEATS_PER_GROUP - 1));
  assign last_group = (group_cnt == GROUP_W'(GROUPS - 1));
  assign drain_ack  = (state == ST_DRAIN) && out_valid && out_ready;

  for (genvar i = 0; i < PO; i++) begin : g_lane
    fc_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .RELU       (RELU)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (accept),
      .last     (last_beat),
      .neuron_a (neuron_a),
      .neuron_b (neuron_b),
      .weight_a (weight_a[i*DATA_WIDTH +: DATA_WIDTH]),
      .weight_b (weight_b[i*DATA_WIDTH +: DATA_WIDTH]),
      .result   (lane_results[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (accept && last_beat && last_group) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_ack) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      group_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_group <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= drain_ack;

      if (accept) begin
        if (last_beat) begin
          beat_cnt  <= '0;
          group_cnt <= last_group ? '0 : group_cnt + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      // A finishing group wins over a handshake in the same cycle, so the
      // new group replaces the one being accepted without a bubble.
      if (accept && last_beat) begin
        out_valid <= 1'b1;
        out_data  <= lane_results;
        out_group <= group_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
